// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and constants for the BCD converter arbiter and its helpers.
package bcd_convert_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE_OK,
        ST_DONE_ERR
    } state_e;

    localparam logic [7:0] BCD_ERR = 8'hFF;
    localparam int DEFAULT_DRAIN_CYCLES = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 63;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_convert_arbiter_rr_priority_pick.sv
// Round-robin picker: first set request strictly after the last grant, wrapping.
module rr_priority_pick #(
    parameter int NUM_REQ = 3,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    logic [IW-1:0] kIdx;

    // Scan from farthest to nearest so the nearest set request is written last and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        kIdx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            kIdx = IW'((int'(last_i) + i) % NUM_REQ);
            if (req_i[kIdx]) begin
                idx_o   = kIdx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one external double-dabble converter among NUM_REQ requesters, with
// a drain period after reset/timeout because the converter itself has no reset.
module bcd_convert_arbiter
    import bcd_convert_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Binary,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [7:0]             o_BCD,
    output logic                   o_Err,
    output logic                   o_Busy,
    output logic                   o_DD_Start,
    output logic [7:0]             o_DD_Binary,
    input  logic [7:0]             i_DD_BCD,
    input  logic                   i_DD_DV
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(maxInt(DRAIN_CYCLES, TIMEOUT_CYCLES) + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [7:0]    bcd_q, bcd_d;
    logic [7:0]    ddBin_q, ddBin_d;

    logic [IW-1:0] pickIdx;
    logic          pickValid;
    logic [7:0]    operand [NUM_REQ];

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (i_Req),
        .last_i  (last_q),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            operand[k] = i_Binary[8*k +: 8];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            bcd_q   <= 8'h00;
            ddBin_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            bcd_q   <= bcd_d;
            ddBin_q <= ddBin_d;
        end
    end

    // DV is only honoured in WAIT, so stale converter pulses in INIT/IDLE are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        bcd_d   = bcd_q;
        ddBin_d = ddBin_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (pickValid) begin
                    grant_d = pickIdx;
                    last_d  = pickIdx;
                    ddBin_d = operand[pickIdx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_DD_DV) begin
                    bcd_d   = i_DD_BCD;
                    state_d = ST_DONE_OK;
                end else if ((cnt_q + CW'(1)) == CW'(TIMEOUT_CYCLES)) begin
                    bcd_d   = BCD_ERR;
                    state_d = ST_DONE_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE_OK: begin
                state_d = ST_IDLE;
            end
            ST_DONE_ERR: begin
                cnt_d   = '0;
                state_d = ST_INIT;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        o_Ack       = '0;
        o_Err       = 1'b0;
        o_DD_Start  = (state_q == ST_ISSUE);
        o_Busy      = (state_q != ST_IDLE);
        o_BCD       = bcd_q;
        o_DD_Binary = ddBin_q;
        if (state_q == ST_DONE_OK || state_q == ST_DONE_ERR) begin
            o_Ack = NUM_REQ'(1) << grant_q;
        end
        if (state_q == ST_DONE_ERR) begin
            o_Err = 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter; the bench plays the external converter.
module tb_bcd_convert_arbiter;

    logic        i_Clk;
    logic        i_Rst_L;
    logic [2:0]  i_Req;
    logic [23:0] i_Binary;
    logic [2:0]  o_Ack;
    logic [7:0]  o_BCD;
    logic        o_Err;
    logic        o_Busy;
    logic        o_DD_Start;
    logic [7:0]  o_DD_Binary;
    logic [7:0]  i_DD_BCD;
    logic        i_DD_DV;

    int compared;
    int mismatched;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] bin;
        int          lat;
        logic [2:0]  expAck;
        logic [7:0]  expDd;
        logic [7:0]  expBcd;
    } vec_t;

    vec_t vecs[8];

    bcd_convert_arbiter #(
        .NUM_REQ(3),
        .DRAIN_CYCLES(32),
        .TIMEOUT_CYCLES(63)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Req       (i_Req),
        .i_Binary    (i_Binary),
        .o_Ack       (o_Ack),
        .o_BCD       (o_BCD),
        .o_Err       (o_Err),
        .o_Busy      (o_Busy),
        .o_DD_Start  (o_DD_Start),
        .o_DD_Binary (o_DD_Binary),
        .i_DD_BCD    (i_DD_BCD),
        .i_DD_DV     (i_DD_DV)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behaviour of the external double-dabble: tens and ones digits only.
    function automatic logic [7:0] ddModel(input logic [7:0] b);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'((b / 10) % 10);
        o = 4'(b % 10);
        return {t, o};
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitStart(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (o_DD_Start) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        checkOutput("start seen", 32'(seen), 32'd1);
    endtask

    task automatic finishTxn(input int lat, input logic [2:0] expAck, input logic [7:0] expBcd,
                             input bit drop, input bit hold);
        tick();
        checkOutput("start one cycle", 32'(o_DD_Start), 32'd0);
        if (drop) i_Req = '0;
        repeat (lat) tick();
        i_DD_BCD = ddModel(o_DD_Binary);
        i_DD_DV  = 1'b1;
        tick();
        i_DD_DV  = 1'b0;
        checkOutput("ack", 32'(o_Ack), 32'(expAck));
        checkOutput("err", 32'(o_Err), 32'd0);
        checkOutput("bcd", 32'(o_BCD), 32'(expBcd));
        if (!hold) i_Req = '0;
        tick();
        checkOutput("ack single pulse", 32'(o_Ack), 32'd0);
        if (!hold) checkOutput("idle not busy", 32'(o_Busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [23:0] bin, input int lat,
                                 input logic [2:0] expAck, input logic [7:0] expDd,
                                 input logic [7:0] expBcd, input bit drop, input bit hold);
        int n;
        i_Req    = req;
        i_Binary = bin;
        waitStart(n);
        checkOutput("start latency", 32'(n), 32'd1);
        checkOutput("dd operand", 32'(o_DD_Binary), 32'(expDd));
        finishTxn(lat, expAck, expBcd, drop, hold);
    endtask

    // Asserts reset mid-cycle, checks reset outputs, then measures the drain with a stray DV.
    task automatic resetAndDrain(input logic [7:0] op);
        int n;
        bit noisy;
        #2;
        i_Rst_L = 1'b0;
        i_DD_DV = 1'b0;
        #1;
        checkOutput("rst ack", 32'(o_Ack), 32'd0);
        checkOutput("rst bcd", 32'(o_BCD), 32'h00);
        checkOutput("rst err", 32'(o_Err), 32'd0);
        checkOutput("rst busy", 32'(o_Busy), 32'd1);
        checkOutput("rst start", 32'(o_DD_Start), 32'd0);
        checkOutput("rst dd operand", 32'(o_DD_Binary), 32'h00);
        i_Req = '0;
        tick();
        tick();
        i_Rst_L  = 1'b1;
        i_Req    = 3'b001;
        i_Binary = {16'h0000, op};
        n = 0;
        noisy = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            i_DD_DV  = (i == 5);
            i_DD_BCD = 8'h88;
            tick();
            if (o_Ack != 3'b000 || o_BCD != 8'h00) noisy = 1'b1;
            if (o_DD_Start) begin
                n = i;
                break;
            end
        end
        i_DD_DV = 1'b0;
        checkOutput("drain length", 32'(n), 32'd33);
        checkOutput("drain ignores dv", 32'(noisy), 32'd0);
        checkOutput("dd operand after drain", 32'(o_DD_Binary), 32'(op));
    endtask

    initial begin
        int n;
        int k;
        compared   = 0;
        mismatched = 0;
        i_Rst_L  = 1'b0;
        i_Req    = '0;
        i_Binary = '0;
        i_DD_BCD = '0;
        i_DD_DV  = 1'b0;

        vecs[0] = '{3'b010, {8'd0,   8'd123, 8'd0},   3,  3'b010, 8'd123, 8'h23};
        vecs[1] = '{3'b100, {8'd99,  8'd0,   8'd0},   24, 3'b100, 8'd99,  8'h99};
        vecs[2] = '{3'b001, {8'd0,   8'd0,   8'd255}, 1,  3'b001, 8'd255, 8'h55};
        vecs[3] = '{3'b011, {8'd0,   8'd86,  8'd11},  5,  3'b010, 8'd86,  8'h86};
        vecs[4] = '{3'b101, {8'd40,  8'd0,   8'd5},   2,  3'b100, 8'd40,  8'h40};
        vecs[5] = '{3'b011, {8'd0,   8'd77,  8'd0},   0,  3'b001, 8'd0,   8'h00};
        vecs[6] = '{3'b001, {8'd0,   8'd0,   8'd47},  62, 3'b001, 8'd47,  8'h47};
        vecs[7] = '{3'b100, {8'd64,  8'd0,   8'd0},   61, 3'b100, 8'd64,  8'h64};

        tick();
        resetAndDrain(8'd42);
        finishTxn(3, 3'b001, 8'h42, 1'b0, 1'b0);

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].req, vecs[v].bin, vecs[v].lat, vecs[v].expAck,
                          vecs[v].expDd, vecs[v].expBcd, 1'b0, 1'b0);
        end

        applyStimulus(3'b111, {8'd99, 8'd58, 8'd7}, 2, 3'b001, 8'd7,  8'h07, 1'b0, 1'b1);
        applyStimulus(3'b111, {8'd99, 8'd58, 8'd7}, 2, 3'b010, 8'd58, 8'h58, 1'b0, 1'b1);
        applyStimulus(3'b111, {8'd99, 8'd58, 8'd7}, 2, 3'b100, 8'd99, 8'h99, 1'b0, 1'b1);
        applyStimulus(3'b111, {8'd99, 8'd58, 8'd7}, 2, 3'b001, 8'd7,  8'h07, 1'b0, 1'b0);

        i_DD_BCD = 8'h66;
        i_DD_DV  = 1'b1;
        tick();
        i_DD_DV  = 1'b0;
        tick();
        checkOutput("idle dv ack", 32'(o_Ack), 32'd0);
        checkOutput("idle dv bcd", 32'(o_BCD), 32'h07);
        checkOutput("idle dv busy", 32'(o_Busy), 32'd0);

        applyStimulus(3'b100, {8'd13, 8'd0, 8'd0}, 4, 3'b100, 8'd13, 8'h13, 1'b1, 1'b0);

        i_Req    = 3'b010;
        i_Binary = {8'd0, 8'd50, 8'd0};
        waitStart(n);
        checkOutput("timeout start latency", 32'(n), 32'd1);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (o_Ack != 3'b000) begin
                k = i;
                break;
            end
        end
        checkOutput("timeout cycles", 32'(k), 32'd64);
        checkOutput("timeout ack", 32'(o_Ack), 32'b010);
        checkOutput("timeout err", 32'(o_Err), 32'd1);
        checkOutput("timeout bcd", 32'(o_BCD), 32'hFF);
        i_Req    = 3'b001;
        i_Binary = {8'd0, 8'd0, 8'd61};
        waitStart(n);
        checkOutput("timeout drain", 32'(n), 32'd34);
        checkOutput("post timeout operand", 32'(o_DD_Binary), 32'd61);
        finishTxn(6, 3'b001, 8'h61, 1'b0, 1'b0);

        i_Req    = 3'b010;
        i_Binary = {8'd0, 8'd88, 8'd0};
        waitStart(n);
        checkOutput("abort start latency", 32'(n), 32'd1);
        tick();
        tick();
        resetAndDrain(8'd34);
        finishTxn(2, 3'b001, 8'h34, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
